// File: rtl/befehls_cache_pkg.sv
// Shared constants and state encoding for the befehls_cache instruction cache.
// One-hot states keep the BC request a single flop decode.
package befehls_cache_pkg;

    localparam int ADR_BITS       = 23;
    localparam int DATA_BITS      = 32;
    localparam int INDEX_BITS_STD = 6;

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        VERGLEICH = 4'b0010,
        ANFRAGE   = 4'b0100,
        ANTWORT   = 4'b1000
    } zustand_t;

    function automatic int tag_breite(input int adr_bits, input int index_bits);
        return adr_bits - index_bits;
    endfunction

    function automatic int zeilen(input int index_bits);
        return 1 << index_bits;
    endfunction

endpackage

// File: rtl/befehls_cache_speicher.sv
// Tag+data line store: one synchronous read port, one write port.
// Valid bits live in the parent so a flush can clear them in one cycle.
module befehls_cache_speicher
    import befehls_cache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_STD,
    parameter int TAG_BITS   = tag_breite(ADR_BITS, INDEX_BITS_STD)
) (
    input  logic                  Clock,
    input  logic                  lese_en,
    input  logic [INDEX_BITS-1:0] lese_index,
    output logic [TAG_BITS-1:0]   lese_tag,
    output logic [DATA_BITS-1:0]  lese_daten,
    input  logic                  schreib_en,
    input  logic [INDEX_BITS-1:0] schreib_index,
    input  logic [TAG_BITS-1:0]   schreib_tag,
    input  logic [DATA_BITS-1:0]  schreib_daten
);

    localparam int ZEILEN = zeilen(INDEX_BITS);

    logic [TAG_BITS+DATA_BITS-1:0] mem [ZEILEN];

    always_ff @(posedge Clock) begin
        if (schreib_en) begin
            mem[schreib_index] <= {schreib_tag, schreib_daten};
        end
    end

    // Output holds between reads so the compare can span two cycles.
    always_ff @(posedge Clock) begin
        if (lese_en) begin
            {lese_tag, lese_daten} <= mem[lese_index];
        end
    end

endmodule

// File: rtl/befehls_cache.sv
// Direct-mapped read-only instruction cache in front of the RAM BC port.
// Optional hit/miss counters: define BC_STATISTIK_EN.
module befehls_cache #(
    parameter int INDEX_BITS = befehls_cache_pkg::INDEX_BITS_STD,
    parameter int ADR_BITS   = befehls_cache_pkg::ADR_BITS
) (
    input  logic                                   Clock,
    input  logic                                   Reset,
    input  logic                                   Lesen,
    input  logic [ADR_BITS-1:0]                    Adresse,
    input  logic                                   Leeren,
    output logic [befehls_cache_pkg::DATA_BITS-1:0] Daten,
    output logic                                   Bereit,
    output logic                                   BCLesen,
    output logic                                   BCSchreiben,
    output logic [ADR_BITS-1:0]                    BCAdresse,
    output logic [befehls_cache_pkg::DATA_BITS-1:0] BCDaten,
    input  logic [befehls_cache_pkg::DATA_BITS-1:0] RAMDaten,
    input  logic                                   BCFertig
`ifdef BC_STATISTIK_EN
    ,
    output logic [31:0]                            TrefferZahl,
    output logic [31:0]                            FehlerZahl
`endif
);

    import befehls_cache_pkg::*;

    localparam int TAG_BITS = tag_breite(ADR_BITS, INDEX_BITS);
    localparam int ZEILEN   = zeilen(INDEX_BITS);

    zustand_t zustand, naechster;

    logic [ADR_BITS-1:0]   adr_q;
    logic [ZEILEN-1:0]     gueltig;
    logic                  leeren_offen;
    logic                  pruefen_q;
    logic                  treffer_q;
    logic [TAG_BITS-1:0]   lese_tag;
    logic [DATA_BITS-1:0]  lese_daten;
    logic [INDEX_BITS-1:0] idx_q;
    logic [TAG_BITS-1:0]   tag_q;

    logic annehmen;
    logic flush;
    logic fuellen;
    logic treffer_jetzt;
    logic fehler_jetzt;

    assign idx_q = adr_q[INDEX_BITS-1:0];
    assign tag_q = adr_q[ADR_BITS-1:INDEX_BITS];

    assign flush    = (zustand == IDLE) && (leeren_offen || Leeren);
    assign annehmen = (zustand == IDLE) && !leeren_offen && !Leeren && Lesen;
    assign fuellen  = (zustand == ANFRAGE) && BCFertig;

    assign treffer_jetzt = (zustand == VERGLEICH) && pruefen_q && treffer_q;
    assign fehler_jetzt  = (zustand == VERGLEICH) && pruefen_q && !treffer_q;

    assign BCSchreiben = 1'b0;
    assign BCDaten     = '0;
    assign BCAdresse   = adr_q;

    befehls_cache_speicher #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_speicher (
        .Clock         (Clock),
        .lese_en       (annehmen),
        .lese_index    (Adresse[INDEX_BITS-1:0]),
        .lese_tag      (lese_tag),
        .lese_daten    (lese_daten),
        .schreib_en    (fuellen),
        .schreib_index (idx_q),
        .schreib_tag   (tag_q),
        .schreib_daten (RAMDaten)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zustand <= IDLE;
        end else begin
            zustand <= naechster;
        end
    end

    always_comb begin
        naechster = zustand;
        BCLesen   = 1'b0;
        unique case (1'b1)
            (zustand == IDLE): begin
                if (annehmen) naechster = VERGLEICH;
            end
            (zustand == VERGLEICH): begin
                if (pruefen_q) naechster = treffer_q ? IDLE : ANFRAGE;
            end
            (zustand == ANFRAGE): begin
                BCLesen = 1'b1;
                if (BCFertig) naechster = ANTWORT;
            end
            (zustand == ANTWORT): begin
                naechster = IDLE;
            end
            default: naechster = IDLE;
        endcase
    end

    // First VERGLEICH cycle registers the tag compare off the array output.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            adr_q        <= '0;
            gueltig      <= '0;
            leeren_offen <= 1'b0;
            pruefen_q    <= 1'b0;
            treffer_q    <= 1'b0;
            Daten        <= '0;
            Bereit       <= 1'b0;
        end else begin
            Bereit    <= 1'b0;
            pruefen_q <= (zustand == VERGLEICH) && !pruefen_q;
            treffer_q <= gueltig[idx_q] && (lese_tag == tag_q);
            if (annehmen) begin
                adr_q <= Adresse;
            end
            if (flush) begin
                gueltig      <= '0;
                leeren_offen <= 1'b0;
            end else if (Leeren) begin
                leeren_offen <= 1'b1;
            end
            if (fuellen) begin
                gueltig[idx_q] <= 1'b1;
                Daten          <= RAMDaten;
            end
            if (treffer_jetzt) begin
                Daten  <= lese_daten;
                Bereit <= 1'b1;
            end
            if (zustand == ANTWORT) begin
                Bereit <= 1'b1;
            end
        end
    end

`ifdef BC_STATISTIK_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            TrefferZahl <= '0;
            FehlerZahl  <= '0;
        end else begin
            if (treffer_jetzt && (TrefferZahl != '1)) begin
                TrefferZahl <= TrefferZahl + 32'd1;
            end
            if (fehler_jetzt && (FehlerZahl != '1)) begin
                FehlerZahl <= FehlerZahl + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_befehls_cache.sv
// Directed bench for befehls_cache with a fixed-latency RAM controller model.
// Stats checks compile in when BC_STATISTIK_EN is defined.
module tb_befehls_cache;

    logic        Clock    = 1'b0;
    logic        Reset    = 1'b1;
    logic        Lesen    = 1'b0;
    logic [22:0] Adresse  = '0;
    logic        Leeren   = 1'b0;
    logic [31:0] RAMDaten = '0;
    logic        BCFertig = 1'b0;
    logic [31:0] Daten;
    logic        Bereit;
    logic        BCLesen;
    logic        BCSchreiben;
    logic [22:0] BCAdresse;
    logic [31:0] BCDaten;
`ifdef BC_STATISTIK_EN
    logic [31:0] TrefferZahl;
    logic [31:0] FehlerZahl;
`endif

    int vektoren = 0;
    int fehler   = 0;
    int ram_cnt  = 0;

    always #5 Clock = ~Clock;

    befehls_cache dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Lesen       (Lesen),
        .Adresse     (Adresse),
        .Leeren      (Leeren),
        .Daten       (Daten),
        .Bereit      (Bereit),
        .BCLesen     (BCLesen),
        .BCSchreiben (BCSchreiben),
        .BCAdresse   (BCAdresse),
        .BCDaten     (BCDaten),
        .RAMDaten    (RAMDaten),
        .BCFertig    (BCFertig)
`ifdef BC_STATISTIK_EN
        ,
        .TrefferZahl (TrefferZahl),
        .FehlerZahl  (FehlerZahl)
`endif
    );

    function automatic logic [31:0] ram_wert(input logic [22:0] a);
        case (a)
            23'h000010: return 32'hDEADBEEF;
            23'h000050: return 32'h5050A0A0;
            23'h000020: return 32'h2020C0DE;
            23'h000030: return 32'h3030F00D;
            default:    return 32'hBAD00000 | {9'd0, a};
        endcase
    endfunction

    // RAM controller: BCFertig pulses once, 5 cycles after BCLesen rises.
    always begin
        @(posedge Clock);
        #1;
        if (Reset || !BCLesen || BCFertig) begin
            BCFertig = 1'b0;
            ram_cnt  = 0;
        end else begin
            ram_cnt++;
            if (ram_cnt == 5) begin
                BCFertig = 1'b1;
                RAMDaten = ram_wert(BCAdresse);
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #3;
    endtask

    task automatic pruefe(input string name, input logic [31:0] ist,
                          input logic [31:0] soll);
        vektoren++;
        assert (ist === soll) else begin
            fehler++;
            $error("FAIL %s: observed %h expected %h", name, ist, soll);
        end
    endtask

    task automatic abruf(input logic [22:0] adr, input logic [31:0] soll,
                         input logic fehlt, input string name);
        int          k;
        int          soll_lat;
        logic        bc_ges;
        logic [22:0] bc_adr;
        logic        f_vor;
        logic        bc_nach;
        logic        ber_nach;
        soll_lat = fehlt ? 8 : 2;
        k        = 0;
        bc_ges   = 1'b0;
        bc_adr   = '0;
        f_vor    = 1'b0;
        bc_nach  = 1'b0;
        ber_nach = 1'b0;
        Lesen    = 1'b1;
        Adresse  = adr;
        step();
        do begin
            step();
            k++;
            if (f_vor) begin
                bc_nach  = BCLesen;
                ber_nach = Bereit;
            end
            f_vor = BCFertig;
            if (BCLesen && !bc_ges) begin
                bc_ges = 1'b1;
                bc_adr = BCAdresse;
            end
        end while (!Bereit && k < 30);
        Lesen = 1'b0;
        pruefe({name, " latenz"}, 32'(k), 32'(soll_lat));
        pruefe({name, " daten"}, Daten, soll);
        pruefe({name, " bclesen"}, 32'(bc_ges), 32'(fehlt));
        if (fehlt) begin
            pruefe({name, " bcadresse"}, 32'(bc_adr), 32'(adr));
            pruefe({name, " bclesen nach fertig"}, 32'(bc_nach), 32'd0);
            pruefe({name, " bereit nach fertig"}, 32'(ber_nach), 32'd0);
        end
        step();
        pruefe({name, " puls"}, 32'(Bereit), 32'd0);
    endtask

    initial begin
        int          k;
        logic [31:0] maske;
        logic        bc_ges;

        #3;
        pruefe("reset bereit", 32'(Bereit), 32'd0);
        pruefe("reset daten", Daten, 32'd0);
        pruefe("reset bclesen", 32'(BCLesen), 32'd0);
        pruefe("reset bcadresse", 32'(BCAdresse), 32'd0);
        pruefe("bcschreiben", 32'(BCSchreiben), 32'd0);
        pruefe("bcdaten", BCDaten, 32'd0);
        step();
        step();
        Reset = 1'b0;
        step();

        abruf(23'h000010, 32'hDEADBEEF, 1'b1, "kalt 10");
        abruf(23'h000010, 32'hDEADBEEF, 1'b0, "treffer 10");
        abruf(23'h000050, 32'h5050A0A0, 1'b1, "konflikt 50");
        abruf(23'h000010, 32'hDEADBEEF, 1'b1, "konflikt 10");

        // Lesen held: hits every 3 cycles.
        Lesen   = 1'b1;
        Adresse = 23'h000010;
        maske   = '0;
        bc_ges  = 1'b0;
        step();
        for (int i = 1; i <= 12; i++) begin
            step();
            if (Bereit) maske[i] = 1'b1;
            if (BCLesen) bc_ges = 1'b1;
            if (i == 9) Lesen = 1'b0;
        end
        pruefe("folge maske", maske, 32'h00000924);
        pruefe("folge bclesen", 32'(bc_ges), 32'd0);
        pruefe("folge daten", Daten, 32'hDEADBEEF);

        // Leeren during ANFRAGE.
        Lesen   = 1'b1;
        Adresse = 23'h000020;
        step();
        step();
        step();
        pruefe("leeren anfrage bclesen", 32'(BCLesen), 32'd1);
        Leeren = 1'b1;
        step();
        Leeren = 1'b0;
        k = 0;
        while (!Bereit && k < 30) begin
            step();
            k++;
        end
        Lesen = 1'b0;
        pruefe("leeren anfrage latenz", 32'(k), 32'd5);
        pruefe("leeren anfrage daten", Daten, 32'h2020C0DE);
        step();
        abruf(23'h000020, 32'h2020C0DE, 1'b1, "nach leeren 20");
        abruf(23'h000020, 32'h2020C0DE, 1'b0, "treffer 20");
        Leeren = 1'b1;
        step();
        Leeren = 1'b0;
        abruf(23'h000020, 32'h2020C0DE, 1'b1, "leeren idle 20");

        // Reset while a miss is outstanding.
        Lesen   = 1'b1;
        Adresse = 23'h000030;
        step();
        step();
        step();
        pruefe("vor reset bclesen", 32'(BCLesen), 32'd1);
        #1;
        Reset = 1'b1;
        #1;
        pruefe("reset mitte bclesen", 32'(BCLesen), 32'd0);
        pruefe("reset mitte bereit", 32'(Bereit), 32'd0);
        Lesen = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();
`ifdef BC_STATISTIK_EN
        pruefe("stat reset treffer", TrefferZahl, 32'd0);
        pruefe("stat reset fehler", FehlerZahl, 32'd0);
`endif
        abruf(23'h000010, 32'hDEADBEEF, 1'b1, "nach reset 10");
        abruf(23'h000010, 32'hDEADBEEF, 1'b0, "stat treffer a");
        abruf(23'h000030, 32'h3030F00D, 1'b1, "stat fehl 30");
        abruf(23'h000010, 32'hDEADBEEF, 1'b0, "stat treffer b");
`ifdef BC_STATISTIK_EN
        pruefe("stat treffer", TrefferZahl, 32'd2);
        pruefe("stat fehler", FehlerZahl, 32'd2);
        Leeren = 1'b1;
        step();
        Leeren = 1'b0;
        step();
        pruefe("stat leeren treffer", TrefferZahl, 32'd2);
        pruefe("stat leeren fehler", FehlerZahl, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vektoren, fehler);
        $finish;
    end

endmodule

// File: doc/befehls_cache.md
Name: befehls_cache

Overview:
Direct-mapped, read-only instruction cache between the CPU fetch stage and the RAM controller's BC port. Hits are served from on-chip tag/data arrays. A miss issues a single-word read to the RAM controller using its Lesen/Fertig handshake, fills the line, then answers the CPU. This block is the BC requester that the RAM controller arbitrates with top priority.

Parameters:
INDEX_BITS, 6, log2 of the line count (64 lines, one 32-bit word per line)
ADR_BITS, 23, word address width, matching the RAM controller cache ports
TAG_BITS, ADR_BITS-INDEX_BITS, derived tag width (localparam, not overridable)

Ports:
Clock  in  1  single clock; everything is on the rising edge
Reset  in  1  asynchronous, active-high reset
Lesen  in  1  CPU fetch request; held with Adresse until Bereit
Adresse  in  23  CPU word address
Leeren  in  1  one-cycle pulse; invalidates all lines
Daten  out  32  instruction word; valid while Bereit=1
Bereit  out  1  one-cycle pulse that completes a fetch
BCLesen  out  1  read request to the RAM controller
BCSchreiben  out  1  constant 0
BCAdresse  out  23  address of the miss
BCDaten  out  32  constant 0
RAMDaten  in  32  the RAM controller's shared DatenAusgabe
BCFertig  in  1  one-cycle completion from the RAM controller

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all valid bits=0.
  - Bereit=0, Daten=0, BCLesen=0, BCAdresse=0; the Leeren-pending flag=0.
  - Tag/data array contents are don't-care.
- States: IDLE, VERGLEICH, ANFRAGE, ANTWORT. One-hot in the package.
- IDLE:
  - If the Leeren-pending flag or Leeren is set: clear all valid bits in one cycle, clear pending, stay in IDLE.
  - Else if Lesen: register Adresse, start the synchronous array read at the index, go to VERGLEICH.
- VERGLEICH:
  - Hit (valid & tag equal): load Daten from the array, set Bereit=1 for exactly one cycle, go to IDLE.
  - Hit latency: Lesen sampled at edge N gives Bereit high in the cycle after edge N+2.
  - Miss: go to ANFRAGE.
- ANFRAGE:
  - BCLesen=1 (decoded from state); BCAdresse holds the registered address.
  - Wait here for any number of cycles, since the RAM controller may be serving another requester.
  - On the edge where BCFertig=1:
    - capture RAMDaten into Daten and into the data array;
    - write the tag and set the valid bit;
    - go to ANTWORT.
- ANTWORT:
  - Bereit=1 for one cycle, BCLesen=0, then go to IDLE.
  - BCLesen must be low in the cycle after BCFertig so the RAM controller returns to IDLE and does not start a second BC access.
- Back-to-back fetches:
  - Lesen still high in the cycle after Bereit counts as a new request (next IDLE edge).
  - Minimum spacing between hits is 3 cycles.
- Leeren outside IDLE:
  - Set the pending flag; the current fetch completes normally, including its fill and valid set.
  - The flush then runs in the next IDLE cycle, before a new lookup starts.
- Lesen dropped during ANFRAGE: the RAM read cannot be aborted. The fill completes and Bereit still pulses; the CPU ignores it.
- Adresse changed while a fetch is outstanding: ignored. The registered address is used.
- Reset mid-miss: BCLesen drops immediately (asynchronously), and the RAM controller is reset by the same Reset. No partial fill remains valid.
- BCFertig outside ANFRAGE: ignored.
- Arithmetic:
  - index = addr[INDEX_BITS-1:0]; tag = addr[ADR_BITS-1:INDEX_BITS].
  - No wrap logic; the address space is exactly 2^23 words.

Optional Feature:
BC_STATISTIK_EN:
- Defined: adds 32-bit outputs TrefferZahl and FehlerZahl.
  - Increment on each hit (VERGLEICH) and each miss (ANFRAGE entry).
  - Both saturate at 0xFFFFFFFF and are cleared by Reset, not by Leeren.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package befehls_cache_pkg:
  - state encodings IDLE/VERGLEICH/ANFRAGE/ANTWORT;
  - ADR_BITS and DATA_BITS=32;
  - index/tag width helper constants.
- Sub-module befehls_cache_speicher:
  - tag+data array with a synchronous read port and a write port (BRAM-inferable);
  - valid bits stay in the parent as flops so the one-cycle flush is possible.

Test Plan:
- Cold miss: Lesen, Adresse=0x000010; RAM model gives BCFertig 5 cycles after BCLesen with RAMDaten=0xDEADBEEF. Expect:
  - BCLesen=1 with BCAdresse=0x000010;
  - BCLesen=0 in the cycle after BCFertig;
  - Bereit one cycle later with Daten=0xDEADBEEF.
- Hit: refetch 0x000010 → Bereit two cycles after Lesen sampled, Daten=0xDEADBEEF, BCLesen never asserted.
- Conflict: fetch 0x000050 (same index 0x10, different tag) → miss with BCAdresse=0x000050; afterwards 0x000010 misses again.
- Flush: Leeren pulse during ANFRAGE for 0x000020 → fill completes with Bereit; next fetch of 0x000020 misses; a second Leeren in IDLE clears valid in one cycle.
- Reset mid-miss: assert Reset while BCLesen=1 → BCLesen=0 and Bereit=0 immediately; after release, fetch 0x000010 misses.
- With BC_STATISTIK_EN, the sequence hit, miss, hit gives TrefferZahl=2, FehlerZahl=1.
